// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ,
    HOLD,
    DROP
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP         = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, redirect inputs and decode output.
interface fetch_unit_if #(
  parameter int unsigned ADDRWIDTH = 32,
  parameter int unsigned DATAWIDTH = 32
);

  logic                 imem_req;
  logic [ADDRWIDTH-1:0] imem_addr;
  logic                 imem_ack;
  logic [DATAWIDTH-1:0] imem_rdata;

  logic                 PCsrc;
  logic [ADDRWIDTH-1:0] branch_pc;
  logic [DATAWIDTH-1:0] ImmOp;

  logic [DATAWIDTH-1:0] instr;
  logic [ADDRWIDTH-1:0] pc;
  logic                 instr_valid;
  logic                 instr_ready;

  modport master (
    output imem_req, imem_addr, instr, pc, instr_valid,
    input  imem_ack, imem_rdata, PCsrc, branch_pc, ImmOp, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr, pc, instr_valid,
    output imem_ack, imem_rdata, PCsrc, branch_pc, ImmOp, instr_ready
  );

endinterface

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC: sequential increment or word-aligned branch target.
module pc_next
  import fetch_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 32,
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic [ADDRWIDTH-1:0] pc_i,
  input  logic                 pcsrc_i,
  input  logic [ADDRWIDTH-1:0] branch_pc_i,
  input  logic [DATAWIDTH-1:0] imm_i,
  output logic [ADDRWIDTH-1:0] pc_next_o
);

  localparam logic [ADDRWIDTH-1:0] ALIGN_MASK = ~ADDRWIDTH'(INSTR_BYTES - 1);

  logic [ADDRWIDTH-1:0] imm_ext;
  logic [ADDRWIDTH-1:0] target;

  // Offset is sign-extended (or truncated) to the address width before the add.
  generate
    if (DATAWIDTH >= ADDRWIDTH) begin : g_trunc
      assign imm_ext = imm_i[ADDRWIDTH-1:0];
    end else begin : g_sext
      assign imm_ext = {{(ADDRWIDTH - DATAWIDTH){imm_i[DATAWIDTH-1]}}, imm_i};
    end
  endgenerate

  always_comb begin
    target    = (branch_pc_i + imm_ext) & ALIGN_MASK;
    pc_next_o = pcsrc_i ? target : pc_i + ADDRWIDTH'(INSTR_BYTES);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, imem req/ack FSM and one-entry output register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned          ADDRWIDTH = 32,
  parameter int unsigned          DATAWIDTH = 32,
  parameter logic [ADDRWIDTH-1:0] RESET_PC  = '0
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam logic [ADDRWIDTH-1:0] ALIGN_MASK = ~ADDRWIDTH'(INSTR_BYTES - 1);

  fetch_state_t         state_q, state_d;
  logic [ADDRWIDTH-1:0] pc_q, pc_d;
  logic [ADDRWIDTH-1:0] stale_q, stale_d;
  logic [DATAWIDTH-1:0] instr_q, instr_d;
  logic [ADDRWIDTH-1:0] pco_q, pco_d;
  logic                 valid_q, valid_d;

  logic                 out_free;
  logic                 req_c;
  logic                 ack_c;
  logic                 capture;
  logic [ADDRWIDTH-1:0] pc_nxt;

  pc_next #(
    .ADDRWIDTH(ADDRWIDTH),
    .DATAWIDTH(DATAWIDTH)
  ) u_pc_next (
    .pc_i       (pc_q),
    .pcsrc_i    (bus.PCsrc),
    .branch_pc_i(bus.branch_pc),
    .imm_i      (bus.ImmOp),
    .pc_next_o  (pc_nxt)
  );

  assign out_free = !valid_q || bus.instr_ready;
  assign ack_c    = req_c && bus.imem_ack;
  assign capture  = (state_q == REQ) && ack_c && !bus.PCsrc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.PCsrc) begin
      state_d = (req_c && !bus.imem_ack) ? DROP : REQ;
    end else begin
      unique case (state_q)
        REQ:     if (!out_free) state_d = HOLD;
        HOLD:    if (bus.instr_ready) state_d = REQ;
        DROP:    if (bus.imem_ack) state_d = REQ;
        default: state_d = REQ;
      endcase
    end
  end

  // Request is gated by rst_n so it reads low for the whole reset window.
  always_comb begin
    req_c = 1'b0;
    unique case (state_q)
      REQ:     req_c = out_free;
      HOLD:    req_c = 1'b0;
      DROP:    req_c = 1'b1;
      default: req_c = 1'b0;
    endcase
    req_c         = req_c && rst_n;
    bus.imem_req  = req_c;
    bus.imem_addr = (state_q == DROP) ? stale_q : pc_q;
  end

  // stale_q freezes the in-flight address while DROP waits out the abandoned ack.
  always_comb begin
    pc_d    = pc_q;
    stale_d = stale_q;
    instr_d = instr_q;
    pco_d   = pco_q;
    valid_d = valid_q;
    if (state_q != DROP) stale_d = pc_q;
    if (valid_q && bus.instr_ready) valid_d = 1'b0;
    if (bus.PCsrc) begin
      pc_d    = pc_nxt;
      valid_d = 1'b0;
    end else if (capture) begin
      pc_d    = pc_nxt;
      instr_d = bus.imem_rdata;
      pco_d   = pc_q;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC & ALIGN_MASK;
      stale_q <= '0;
      instr_q <= '0;
      pco_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      stale_q <= stale_d;
      instr_q <= instr_d;
      pco_q   <= pco_d;
      valid_q <= valid_d;
    end
  end

  assign bus.instr       = instr_q;
  assign bus.pc          = pco_q;
  assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios plus randomized memory latency, stalls and redirects.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDRWIDTH(32), .DATAWIDTH(32)) bus0 ();
  fetch_unit_if #(.ADDRWIDTH(32), .DATAWIDTH(32)) bus1 ();

  fetch_unit #(.ADDRWIDTH(32), .DATAWIDTH(32), .RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  fetch_unit #(.ADDRWIDTH(32), .DATAWIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  typedef struct {
    logic [31:0] start;
    int unsigned cyc;
  } seg_t;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  int unsigned xfers = 0;
  seg_t        sb[$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // dut1: zero-wait memory, decode always ready
  assign bus1.imem_ack   = bus1.imem_req;
  assign bus1.imem_rdata = memfn(bus1.imem_addr);

  // dut0 memory: per-request latency, ack after that many waiting cycles (0 = same cycle)
  bit          lat_random = 1'b0;
  logic [31:0] slow_addr  = 32'h1;
  int unsigned slow_lat   = 0;
  int unsigned wait_cnt   = 0;
  int unsigned cur_lat    = 0;

  always @(posedge clk) begin
    #2;
    if (bus0.imem_req && wait_cnt == 0)
      cur_lat = lat_random ? $urandom_range(0, 3) : ((bus0.imem_addr == slow_addr) ? slow_lat : 0);
    bus0.imem_ack   = bus0.imem_req && (wait_cnt >= cur_lat);
    bus0.imem_rdata = memfn(bus0.imem_addr);
    #4;
    if (!bus0.imem_req || bus0.imem_ack) wait_cnt = 0;
    else wait_cnt++;
  end

  // Monitor: every transfer must follow the program order of the most recent segment
  logic [31:0] exp_pc    = '0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wait = 1'b0;
    end else begin
      if (bus0.instr_valid && bus0.instr_ready) begin
        xfers++;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          exp_pc = sb[0].start;
          void'(sb.pop_front());
        end
        chk("xfer_pc", bus0.pc, exp_pc);
        chk("xfer_instr", bus0.instr, memfn(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      if (prev_wait) begin
        chk("req_held", {31'd0, bus0.imem_req}, 32'd1);
        chk("addr_stable", bus0.imem_addr, prev_addr);
      end
      if (bus0.imem_req) chk("addr_align", {30'd0, bus0.imem_addr[1:0]}, 32'd0);
      prev_wait = bus0.imem_req && !bus0.imem_ack;
      prev_addr = bus0.imem_addr;
    end
  end

  task automatic push_seg(input logic [31:0] start);
    seg_t s;
    s.start = start;
    s.cyc   = cyc;
    sb.push_back(s);
  endtask

  task automatic step(input logic rdy, input logic psrc, input logic [31:0] bpc,
                      input logic [31:0] imm, input logic psrc1);
    @(posedge clk);
    #1;
    bus0.instr_ready = rdy;
    bus0.PCsrc       = psrc;
    bus0.branch_pc   = bpc;
    bus0.ImmOp       = imm;
    bus1.PCsrc       = psrc1;
    if (psrc) push_seg((bpc + imm) & 32'hFFFF_FFFC);
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge of the first cycle after release
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus0.PCsrc = 1'b0;
    bus1.PCsrc = 1'b0;
    #1;
    chk("rst_async_req", {31'd0, bus0.imem_req}, 32'd0);
    chk("rst_async_valid", {31'd0, bus0.instr_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_instr", bus0.instr, 32'd0);
    chk("rst_pc", bus0.pc, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus0.instr_ready = 1'b1;
    push_seg(32'h0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned x0;
    logic        r, p;
    logic [31:0] b, i;

    rst_n            = 1'b0;
    bus0.instr_ready = 1'b1;
    bus0.PCsrc       = 1'b0;
    bus0.branch_pc   = '0;
    bus0.ImmOp       = '0;
    bus0.imem_ack    = 1'b0;
    bus0.imem_rdata  = '0;
    bus1.instr_ready = 1'b1;
    bus1.PCsrc       = 1'b0;
    bus1.branch_pc   = 32'hFFFF_FFF0;
    bus1.ImmOp       = 32'h0000_0016;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("por_valid", {31'd0, bus0.instr_valid}, 32'd0);
    chk("por_req", {31'd0, bus0.imem_req}, 32'd0);

    // Stream at zero wait, plus wrap/align on dut1
    do_reset();
    chk("s1_req", {31'd0, bus0.imem_req}, 32'd1);
    chk("s1_addr", bus0.imem_addr, 32'h0);
    chk("w1_addr", bus1.imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 0, 0, 1'b1);
    chk("s2_addr", bus0.imem_addr, 32'h4);
    chk("s2_pc", bus0.pc, 32'h0);
    chk("w2_addr_wrap", bus1.imem_addr, 32'h0);
    chk("w2_pc", bus1.pc, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    chk("s3_addr", bus0.imem_addr, 32'h8);
    chk("s3_pc", bus0.pc, 32'h4);
    chk("w3_addr_align", bus1.imem_addr, 32'h4);
    chk("w3_valid", {31'd0, bus1.instr_valid}, 32'd0);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    chk("s4_addr", bus0.imem_addr, 32'hC);
    chk("s4_valid", {31'd0, bus0.instr_valid}, 32'd1);
    chk("w4_pc", bus1.pc, 32'h4);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    chk("s5_pc", bus0.pc, 32'hC);

    // Backpressure: three stalled cycles on the first word
    do_reset();
    for (int unsigned k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 0, 0, 1'b0);
      chk("bp_req_low", {31'd0, bus0.imem_req}, 32'd0);
      chk("bp_pc_held", bus0.pc, 32'h0);
      chk("bp_valid", {31'd0, bus0.instr_valid}, 32'd1);
    end
    step(1'b1, 1'b0, 0, 0, 1'b0);
    chk("bp_drain_req", {31'd0, bus0.imem_req}, 32'd0);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    chk("bp_next_addr", bus0.imem_addr, 32'h4);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    chk("bp_next_pc", bus0.pc, 32'h4);

    // Redirect while the fetch at 0x8 waits three cycles
    slow_addr = 32'h8;
    slow_lat  = 3;
    do_reset();
    step(1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    chk("rd_wait_addr", bus0.imem_addr, 32'h8);
    step(1'b1, 1'b1, 32'h4, 32'hFFFF_FFFC, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    chk("rd_stale_addr", bus0.imem_addr, 32'h8);
    chk("rd_stale_valid", {31'd0, bus0.instr_valid}, 32'd0);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    chk("rd_drop_valid", {31'd0, bus0.instr_valid}, 32'd0);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    chk("rd_target_addr", bus0.imem_addr, 32'h0);
    chk("rd_target_valid", {31'd0, bus0.instr_valid}, 32'd0);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    chk("rd_first_pc", bus0.pc, 32'h0);
    chk("rd_first_valid", {31'd0, bus0.instr_valid}, 32'd1);
    slow_addr = 32'h1;

    // Redirect in the same cycle as the ack
    do_reset();
    step(1'b1, 1'b1, 32'h10, 32'h20, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    chk("sim_valid", {31'd0, bus0.instr_valid}, 32'd0);
    chk("sim_addr", bus0.imem_addr, 32'h30);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    chk("sim_pc", bus0.pc, 32'h30);

    // Randomized latency, stalls and redirects
    lat_random = 1'b1;
    do_reset();
    x0 = xfers;
    for (int unsigned n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 3) != 0);
      p = ($urandom_range(0, 15) == 0);
      b = $urandom;
      i = $urandom_range(0, 1) ? $urandom : (32'($urandom_range(0, 255)) - 32'd128);
      step(r, p, b, i, 1'b0);
    end
    step(1'b1, 1'b0, 0, 0, 1'b0);
    chk("rand_progress", {31'd0, (xfers - x0) > 50}, 32'd1);

    repeat (4) step(1'b1, 1'b0, 0, 0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
